// File: rtl/ram_word_sequencer_pkg.sv
// Shared types for the RAM word sequencer: FSM state encoding and word-count helper.
package ram_word_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  function automatic int words_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/ram_word_sequencer_if.sv
// Requester <-> sequencer bus: request fields in, handshake and word-line drive out.
interface ram_word_sequencer_if #(
  parameter int ADDR_W = 2,
  parameter int BL_W   = 2
);
  import ram_word_seq_pkg::*;
  localparam int WORDS = words_of(ADDR_W);

  logic              memory_en;
  logic              req;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [BL_W-1:0]   burst_len;
  logic              ack;
  logic              busy;
  logic [WORDS-1:0]  word;
  logic              write_en;
  logic              done;
  logic              abort;

  modport master (
    output memory_en, req, write, address, burst_len,
    input  ack, busy, word, write_en, done, abort
  );

  modport slave (
    input  memory_en, req, write, address, burst_len,
    output ack, busy, word, write_en, done, abort
  );
endinterface

// File: rtl/ram_word_sequencer_decoder.sv
// Combinational binary-to-one-hot word-line decoder; all-zero when disabled.
module ram_onehot_decoder
  import ram_word_seq_pkg::*;
#(
  parameter int ADDR_W = 2
) (
  input  logic [ADDR_W-1:0]           address,
  input  logic                        en,
  output logic [words_of(ADDR_W)-1:0] word
);
  always_comb begin
    word = '0;
    if (en) word[address] = 1'b1;
  end
endmodule

// File: rtl/ram_word_sequencer.sv
// Registered word-line sequencer: req/ack handshake, one-cycle recovery, abort on enable drop.
// Burst/auto-increment support is built only when RAM_WORD_SEQ_BURST_EN is defined.
module ram_word_sequencer
  import ram_word_seq_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int BL_W   = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  ram_word_sequencer_if.slave  bus
);
  localparam int WORDS = words_of(ADDR_W);

  state_e            r_state;
  logic              r_ack, r_busy, r_we, r_done, r_abort;
  logic [WORDS-1:0]  r_word;
  logic [ADDR_W-1:0] w_dec_addr;
  logic [WORDS-1:0]  w_dec_word;
  logic              w_accept, w_first_last, w_last, w_next_last;

  assign w_accept = bus.req && bus.memory_en;

`ifdef RAM_WORD_SEQ_BURST_EN
  logic [ADDR_W-1:0] r_addr;
  logic [BL_W-1:0]   r_cnt;

  // Decode the start address on acceptance, otherwise the next (wrapping) address.
  assign w_dec_addr   = (r_state == ST_IDLE) ? bus.address : r_addr + 1'b1;
  assign w_first_last = (bus.burst_len == '0);
  assign w_last       = (r_cnt == '0);
  assign w_next_last  = (r_cnt == BL_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_cnt  <= '0;
    end else if (r_state == ST_IDLE && w_accept) begin
      r_addr <= bus.address;
      r_cnt  <= bus.burst_len;
    end else if (r_state == ST_ACTIVE && !w_last && bus.memory_en) begin
      r_addr <= r_addr + 1'b1;
      r_cnt  <= r_cnt - 1'b1;
    end
  end
`else
  logic w_unused_bl;

  assign w_unused_bl  = ^bus.burst_len;
  assign w_dec_addr   = bus.address;
  assign w_first_last = 1'b1;
  assign w_last       = 1'b1;
  assign w_next_last  = 1'b0;
`endif

  ram_onehot_decoder #(.ADDR_W(ADDR_W)) u_dec (
    .address (w_dec_addr),
    .en      (bus.memory_en),
    .word    (w_dec_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      r_word  <= '0;
    end else begin
      r_ack   <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_ACTIVE;
            r_ack   <= 1'b1;
            r_busy  <= 1'b1;
            r_word  <= w_dec_word;
            r_we    <= bus.write;
            r_done  <= w_first_last;
          end
        end
        ST_ACTIVE: begin
          // Completion wins over an enable drop on the last word's edge.
          if (w_last) begin
            r_state <= ST_RECOVER;
            r_word  <= '0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
          end else if (!bus.memory_en) begin
            r_state <= ST_RECOVER;
            r_word  <= '0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_abort <= 1'b1;
          end else begin
            r_word  <= w_dec_word;
            r_done  <= w_next_last;
          end
        end
        ST_RECOVER: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_word  <= '0;
          r_we    <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack      = r_ack;
  assign bus.busy     = r_busy;
  assign bus.word     = r_word;
  assign bus.write_en = r_we;
  assign bus.done     = r_done;
  assign bus.abort    = r_abort;
endmodule

// File: doc/ram_word_sequencer.md
# ram_word_sequencer

Parametrised, registered successor to the RAM word decoder. Decodes an `ADDR_W`-bit address into a one-hot word-line select over `2**ADDR_W` words and runs a small access state machine: a request/acknowledge handshake, optional auto-incrementing bursts with wrap-around, an abort path when the memory enable drops, and a one-cycle recovery gap between accesses. It sits between the memory-access requester and the RAM word array; its `word` and `write_en` outputs drive the array directly.

## Interface
- `ADDR_W`, 2: address width; word count `WORDS = 2**ADDR_W` (localparam).
- `BL_W`, 2: burst-length field width; a burst is `burst_len+1` words, so the maximum burst is `2**BL_W` words.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `memory_en`  in  1  global memory enable; gates acceptance and aborts an active burst.
- `req`  in  1  access request; held high until `ack`.
- `write`  in  1  access type (1 = write), sampled with `req`.
- `address`  in  `ADDR_W`  start word address, sampled with `req`.
- `burst_len`  in  `BL_W`  words minus one, sampled with `req`.
- `ack`  out  1  one-cycle pulse: request accepted.
- `busy`  out  1  high whenever the state is not IDLE.
- `word`  out  `WORDS`  one-hot word-line select; all zero when no word is active.
- `write_en`  out  1  high while a write word is active.
- `done`  out  1  one-cycle pulse in the last word of a completed access.
- `abort`  out  1  one-cycle pulse when a burst is cut short.

## Operation
- All outputs are registered. On reset, every output is 0 and the state is IDLE.
- States are IDLE, ACTIVE and RECOVER.
- **IDLE**
  - Transition: `req && memory_en` at an edge moves to ACTIVE.
  - Latched at that edge: `cur_addr = address`, `cnt = burst_len`, `wr = write`.
  - Otherwise the block stays in IDLE.
- **ACTIVE**
  - Outputs each cycle: `word = onehot(cur_addr)`, `write_en = wr`.
  - `ack` is 1 only in the first ACTIVE cycle.
  - Normal step: `cur_addr` increments modulo `WORDS` (wrap from `WORDS-1` to 0) and `cnt` decrements.
  - Completion: when `cnt == 0`, `done` is 1 in that word's cycle and the next state is RECOVER.
- **Abort**
  - Condition: `memory_en` is sampled low during ACTIVE.
  - Response at that edge: the next state is RECOVER, `word` and `write_en` go to 0, and `abort` pulses for the RECOVER cycle.
  - `done` is not asserted for an aborted access.
  - The word active in the cycle before the abort edge counts as issued.
- **RECOVER**
  - Exactly one cycle with `word = 0` and `write_en = 0`, then IDLE.
- **Requests while busy**
  - `req` is ignored while the state is not IDLE; there is no queuing.
  - A `req` that stays high is accepted at the first edge in IDLE.
- **Reset mid-access**
  - `rst_n` low clears `word` and `write_en` immediately (asynchronously).
  - No `done` or `abort` is produced.

## Timing
- Latency: the `req` edge at cycle 0 gives the first word, with `ack`, in cycle 1.
- An N-word burst occupies cycles 1..N, with `done` in cycle N.
- RECOVER is cycle N+1 and IDLE is cycle N+2.
- The earliest next first word is cycle N+3.
- Back-to-back single-word accesses therefore run at most one every 3 cycles.
- `busy` is high from cycle 1 through cycle N+1.
- Simultaneous events:
  - `memory_en` low at the same edge `cnt` reaches 0: treated as a completed access (`done` pulses, no `abort`).
  - `req` together with `memory_en` low in IDLE: no acceptance.

## Configuration
- Macro: `RAM_WORD_SEQ_BURST_EN`.
- Defined: burst behaviour exactly as above.
- Undefined:
  - `burst_len` is ignored and every access is one word (`cnt` is forced to 0).
  - The `burst_len` port still exists.
  - The increment and wrap logic is not generated.

## Structure
- Package `ram_word_seq_pkg` holds the state enum (IDLE/ACTIVE/RECOVER) and a localparam helper for `WORDS` from `ADDR_W`.
- Sub-module `ram_onehot_decoder` is the parametrised combinational binary-to-one-hot decoder:
  - inputs `address` (`ADDR_W`) and `en`; output `word` (`WORDS`).
  - its output is registered in the sequencer.

## Test plan
All tests use `ADDR_W=2`, `BL_W=2`, with `RAM_WORD_SEQ_BURST_EN` defined unless stated.
- Reset: assert `rst_n=0` → all outputs 0; release with no `req` → `word` stays 4'b0000 and `busy=0`.
- Single write, `address=2`, `burst_len=0`, `write=1`:
  - cycle 1: `word=4'b0100`, `ack=1`, `write_en=1`, `done=1`.
  - cycle 2: `word=0`, `busy=1`.
  - cycle 3: `busy=0`.
- Wrapping read burst, `address=3`, `burst_len=2` → `word` is 4'b1000, 4'b0001, 4'b0010 over three cycles; `done` only on the third; `write_en=0` throughout.
- Abort: burst with `address=0`, `burst_len=3`; drop `memory_en` during the second word (4'b0010) → next cycle `word=0` and `abort=1`, `done` never asserted, `busy` low one cycle later.
- Held `req` while busy → ignored until IDLE, then accepted with `ack` exactly once; `req` with `memory_en=0` in IDLE → no `ack`.
- With the macro undefined, `burst_len=3`, `address=1` → a single `word=4'b0010` with `done`; async reset mid-burst → `word` clears without a clock edge.
